// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for a single-port memory macro: one backscatter read
// port (absolute priority) and two write ports shared round-robin.
module mem_port_arbiter #(
  parameter int unsigned ACT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [5:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  input  logic        epc_req,
  input  logic [5:0]  epc_addr,
  input  logic [2:0]  epc_sel,
  input  logic [15:0] epc_wdata,
  output logic        epc_ack,
  input  logic        adc_req,
  input  logic [5:0]  adc_addr,
  input  logic [2:0]  adc_sel,
  input  logic [15:0] adc_wdata,
  output logic        adc_ack,
  input  logic        tx_enable,
  input  logic [15:0] mem_read_in,
  output logic [15:0] mem_data_out,
  output logic [5:0]  mem_address,
  output logic [2:0]  mem_sel,
  output logic        PC_B,
  output logic        WE,
  output logic        SE,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ACT  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_R0   = 2'd1;
  localparam logic [1:0] G_R1   = 2'd2;
  localparam logic [1:0] G_R2   = 2'd3;
  localparam logic [2:0] ACT_LAST = 3'(ACT_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  owner_q;
  logic        is_wr_q;
  logic        rr_q;       // 0: R1 favoured next, 1: R2 favoured next
  logic [2:0]  cnt_q;
  logic        pcb_q;
  logic        we_q;
  logic        se_q;
  logic [5:0]  addr_q;
  logic [2:0]  sel_q;
  logic [15:0] data_q;
  logic [15:0] rd_data_q;
  logic        rd_ack_q;
  logic        epc_ack_q;
  logic        adc_ack_q;

  logic        adc_elig_s;
  logic [1:0]  gnt_s;
  logic [5:0]  addr_s;
  logic [2:0]  sel_s;
  logic [15:0] wdata_s;

  assign adc_elig_s = adc_req & ~tx_enable;

  // Winner selection and payload mux for the IDLE grant decision
  always_comb begin
    gnt_s   = G_NONE;
    addr_s  = 6'd0;
    sel_s   = 3'd0;
    wdata_s = 16'h0000;
    if (rd_req) begin
      gnt_s = G_R0;
    end else if (epc_req && adc_elig_s) begin
      gnt_s = rr_q ? G_R2 : G_R1;
    end else if (epc_req) begin
      gnt_s = G_R1;
    end else if (adc_elig_s) begin
      gnt_s = G_R2;
    end else begin
      gnt_s = G_NONE;
    end
    case (gnt_s)
      G_R0: begin
        addr_s = rd_addr;
        sel_s  = rd_sel;
      end
      G_R1: begin
        addr_s  = epc_addr;
        sel_s   = epc_sel;
        wdata_s = epc_wdata;
      end
      G_R2: begin
        addr_s  = adc_addr;
        sel_s   = adc_sel;
        wdata_s = adc_wdata;
      end
      default: begin
        addr_s  = 6'd0;
        sel_s   = 3'd0;
        wdata_s = 16'h0000;
      end
    endcase
  end

  // Access sequencer; every macro strobe and ack is a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= G_NONE;
      is_wr_q   <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= 3'd0;
      pcb_q     <= 1'b1;
      we_q      <= 1'b0;
      se_q      <= 1'b0;
      addr_q    <= 6'd0;
      sel_q     <= 3'd0;
      data_q    <= 16'h0000;
      rd_data_q <= 16'h0000;
      rd_ack_q  <= 1'b0;
      epc_ack_q <= 1'b0;
      adc_ack_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_s != G_NONE) begin
            state_q <= S_PRE;
            owner_q <= gnt_s;
            is_wr_q <= (gnt_s != G_R0);
            addr_q  <= addr_s;
            sel_q   <= sel_s;
            data_q  <= (gnt_s != G_R0) ? wdata_s : 16'h0000;
            pcb_q   <= 1'b0;
            if (gnt_s == G_R1) begin
              rr_q <= 1'b1;
            end else if (gnt_s == G_R2) begin
              rr_q <= 1'b0;
            end else begin
              rr_q <= rr_q;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PRE: begin
          state_q <= S_ACT;
          pcb_q   <= 1'b1;
          we_q    <= is_wr_q;
          se_q    <= ~is_wr_q;
          cnt_q   <= 3'd0;
        end
        S_ACT: begin
          if (cnt_q == ACT_LAST) begin
            state_q   <= S_FIN;
            we_q      <= 1'b0;
            se_q      <= 1'b0;
            rd_ack_q  <= (owner_q == G_R0);
            epc_ack_q <= (owner_q == G_R1);
            adc_ack_q <= (owner_q == G_R2);
            if (!is_wr_q) begin
              rd_data_q <= mem_read_in;
            end else begin
              rd_data_q <= rd_data_q;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_FIN: begin
          state_q   <= S_IDLE;
          owner_q   <= G_NONE;
          rd_ack_q  <= 1'b0;
          epc_ack_q <= 1'b0;
          adc_ack_q <= 1'b0;
          addr_q    <= 6'd0;
          sel_q     <= 3'd0;
          data_q    <= 16'h0000;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_ack       = rd_ack_q;
  assign rd_data      = rd_data_q;
  assign epc_ack      = epc_ack_q;
  assign adc_ack      = adc_ack_q;
  assign mem_data_out = data_q;
  assign mem_address  = addr_q;
  assign mem_sel      = sel_q;
  assign PC_B         = pcb_q;
  assign WE           = we_q;
  assign SE           = se_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ACT_CYCLES, default 2, legal range 1..7: cycles WE/SE held active per access.
REQ-002 Ports use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 rd_req / rd_addr / rd_sel  input  1/6/3  backscatter read request (requester R0), address, bank select.
REQ-006 rd_ack / rd_data  output  1/16  read-complete pulse and captured word.
REQ-007 epc_req / epc_addr / epc_sel / epc_wdata  input  1/6/3/16  EPC write request (R1).
REQ-008 epc_ack  output  1  EPC write-complete pulse.
REQ-009 adc_req / adc_addr / adc_sel / adc_wdata  input  1/6/3/16  ADC log write request (R2).
REQ-010 adc_ack  output  1  ADC write-complete pulse.
REQ-011 tx_enable  input  1  backscatter active; blocks R2 grants.
REQ-012 mem_read_in  input  16  macro read data.
REQ-013 mem_data_out / mem_address / mem_sel  output  16/6/3  macro write data, wordline address, bank select.
REQ-014 PC_B / WE / SE  output  1/1/1  precharge (active low), write enable, sense enable.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, PRE, ACT, FIN; transitions are registered, one per clk edge except ACT.
REQ-017 IDLE: if any eligible request, latch winner's addr/sel/wdata/direction and go to PRE; else stay.
REQ-018 Priority: R0 absolute highest; R1 and R2 alternate round-robin when both are eligible, with R1 favoured after reset.
REQ-019 R2 is eligible only when tx_enable=0; R0 and R1 ignore tx_enable.
REQ-020 PRE lasts exactly 1 cycle: PC_B=0, WE=SE=0, mem_address/mem_sel driven from latched values.
REQ-021 ACT lasts exactly ACT_CYCLES cycles: PC_B=1, WE=1 for writes or SE=1 for reads (never both), address/sel/data held stable.
REQ-022 On the ACT->FIN edge, a read captures mem_read_in into rd_data; rd_data holds until the next read capture.
REQ-023 FIN lasts 1 cycle: WE=SE=0, the granted requester's ack=1 for this cycle only, then go to IDLE.
REQ-024 Latency: request seen in IDLE at cycle 0 -> ack high in cycle ACT_CYCLES+2; back-to-back grants are spaced ACT_CYCLES+3 cycles apart.
REQ-025 Requesters hold req and payload until ack; payload changes after the IDLE grant cycle are ignored.
REQ-026 If req deasserts after grant, the access completes and ack still pulses.
REQ-027 If req is still high in the cycle after ack, it is a new request.
REQ-028 At most one ack is high in any cycle; ack is never issued to a requester that was not granted.
REQ-029 mem_data_out carries latched wdata during PRE/ACT/FIN of writes and 0 otherwise.
REQ-030 In IDLE, mem_address and mem_sel are 0.
REQ-031 The round-robin pointer advances only on an R1 or R2 grant; R0 grants leave it unchanged.
REQ-032 tx_enable rising during an in-flight R2 access does not abort it.

Reset
REQ-033 Reset asserted at any time, including mid-ACT, forces IDLE asynchronously.
REQ-034 Reset values: PC_B=1; WE=0; SE=0; mem_address=0; mem_sel=0; mem_data_out=0; all acks=0; rd_data=0; busy=0; RR pointer=R1.
REQ-035 An access interrupted by reset is not acked and is not retried; requesters re-request.

Verification
REQ-036 Single read, ACT_CYCLES=2: rd_req, rd_addr=6'h05, rd_sel=1, mem_read_in=16'hBEEF -> PC_B low cycle 1, SE high cycles 2-3, rd_ack cycle 4, rd_data=16'hBEEF.
REQ-037 Simultaneous rd/epc/adc requests with tx_enable=0 -> grant order R0, R1, R2; acks 5 cycles apart; WE never high during R0 access.
REQ-038 epc_req and adc_req held continuously -> grants alternate R1,R2,R1,R2; neither starves.
REQ-039 adc_req with tx_enable=1 -> no grant, busy=0; drop tx_enable -> PRE next cycle; adc_ack 4 cycles later with mem_data_out=adc_wdata during WE.
REQ-040 Reset pulsed in second ACT cycle of an epc write -> next cycle all outputs at reset values, no epc_ack; re-request completes normally.
REQ-041 epc_wdata changed after grant, and epc_req dropped during ACT -> original data written, epc_ack still pulses once.
